// File: rtl/fma_pipe_ctrl_if.sv
// Handshake/control bundle between the FMA sequencer and its neighbours.
// Latency: none (wires only).
// Backpressure: carries in_ready_o / out_ready_i; no storage of its own.
//
// Ports (by modport):
//   master : drives in_valid_i/in_tag_i/in_rm_i/in_special_i, flush_i, drain_i, out_ready_i;
//            observes in_ready_o, out_*, stage_en_o, dp_en_o, occupancy_o, drain_done_o.
//   slave  : the sequencer itself, mirror image of master.
interface fma_pipe_ctrl_if #(
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 5,
    parameter int RM_W       = 3
);
    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    // upstream op side
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [TAG_W-1:0]      in_tag_i;
    logic [RM_W-1:0]       in_rm_i;
    logic                  in_special_i;

    // pipeline-wide control
    logic                  flush_i;
    logic                  drain_i;

    // downstream result side
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [TAG_W-1:0]      out_tag_o;
    logic [RM_W-1:0]       out_rm_o;
    logic                  out_special_o;

    // datapath enables and status
    logic [NUM_STAGES-1:0] stage_en_o;
    logic [NUM_STAGES-1:0] dp_en_o;
    logic [OCC_W-1:0]      occupancy_o;
    logic                  drain_done_o;

    modport master (
        output in_valid_i, in_tag_i, in_rm_i, in_special_i,
        output flush_i, drain_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_tag_o, out_rm_o, out_special_o,
        input  stage_en_o, dp_en_o, occupancy_o, drain_done_o
    );

    modport slave (
        input  in_valid_i, in_tag_i, in_rm_i, in_special_i,
        input  flush_i, drain_i, out_ready_i,
        output in_ready_o, out_valid_o, out_tag_o, out_rm_o, out_special_o,
        output stage_en_o, dp_en_o, occupancy_o, drain_done_o
    );
endinterface

// File: rtl/fma_pipe_ctrl.sv
// Sequencer for the 4-stage FMA datapath (align, add, normalize, round): per-stage valid/tag/rm/special.
// Latency: NUM_STAGES cycles accept-to-out_valid_o with no stall; 1 op/cycle throughput, strict order.
// Backpressure: out_ready_i low holds S3 and ripples back through full stages only (bubbles collapse).
//
// Ports:
//   clk_i   : clock, all state on rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : fma_pipe_ctrl_if.slave -- op handshake in, result handshake out, flush/drain control,
//             per-stage register enables (stage_en_o), datapath clock-gate enables (dp_en_o),
//             in-flight count (occupancy_o) and a one-cycle drain completion pulse (drain_done_o).
module fma_pipe_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int TAG_W      = 5,
    parameter int RM_W       = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fma_pipe_ctrl_if.slave   bus
);
    localparam int OCC_W = $clog2(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0]            v_q,   v_d;
    logic [NUM_STAGES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [NUM_STAGES-1:0][RM_W-1:0]  rm_q,  rm_d;
    logic [NUM_STAGES-1:0]            sp_q,  sp_d;
    logic [OCC_W-1:0]                 occ_q, occ_d;
    state_e                           state_q, state_d;
    // Set once a drain has completed; blocks another pulse until drain_i is released.
    logic                             drain_seen_q, drain_seen_d;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] adv;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] dp_en;
    logic                  in_ready;
    logic                  accept;
    logic                  out_valid;
    logic                  deq;
    logic                  drain_done;

    // Advance chain: a stage may move if it is empty or everything ahead of it moves.
    // This is what lets a bubble be squeezed out while the output is stalled.
    always_comb begin
        adv = '0;
        adv[NUM_STAGES-1] = ~v_q[NUM_STAGES-1] | bus.out_ready_i;
        for (int k = NUM_STAGES - 2; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    always_comb begin
        // drain_i also gates ready so that the cycle requesting a drain never accepts,
        // and a drain held high after completion keeps the input closed.
        in_ready  = adv[0] & ~bus.flush_i & (state_q != S_DRAIN) & ~bus.drain_i;
        accept    = bus.in_valid_i & in_ready;
        out_valid = v_q[NUM_STAGES-1] & ~bus.flush_i;
        deq       = out_valid & bus.out_ready_i;

        stage_en    = '0;
        dp_en       = '0;
        stage_en[0] = accept;
        dp_en[0]    = accept & ~bus.in_special_i;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_en[k] = adv[k] & v_q[k-1] & ~bus.flush_i;
            // Special-case ops take the bypass path; keep the arithmetic clocks quiet.
            dp_en[k]    = adv[k] & v_q[k-1] & ~bus.flush_i & ~sp_q[k-1];
        end

        drain_done = (state_q == S_DRAIN) & (occ_q == '0) & ~bus.flush_i;
    end

    // Pipeline valid/field shift
    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        rm_d  = rm_q;
        sp_d  = sp_q;

        if (stage_en[0]) begin
            v_d[0]   = 1'b1;
            tag_d[0] = bus.in_tag_i;
            rm_d[0]  = bus.in_rm_i;
            sp_d[0]  = bus.in_special_i;
        end else if (adv[0]) begin
            v_d[0]   = 1'b0;
        end

        for (int k = 1; k < NUM_STAGES; k++) begin
            if (stage_en[k]) begin
                v_d[k]   = 1'b1;
                tag_d[k] = tag_q[k-1];
                rm_d[k]  = rm_q[k-1];
                sp_d[k]  = sp_q[k-1];
            end else if (adv[k]) begin
                v_d[k]   = 1'b0;
            end
        end

        if (bus.flush_i) begin
            v_d = '0;
        end
    end

    // Occupancy counter: accept and output handshake in the same cycle cancel out.
    always_comb begin
        occ_d = occ_q;
        if (accept && !deq) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (deq && !accept) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (bus.flush_i) begin
            occ_d = '0;
        end
    end

    // Mode FSM: next state
    always_comb begin
        state_d      = state_q;
        drain_seen_d = drain_seen_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.drain_i && !drain_seen_q) begin
                    state_d = S_DRAIN;
                end else if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.drain_i) begin
                    state_d = S_DRAIN;
                end else if (occ_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d      = S_IDLE;
                    drain_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!bus.drain_i) begin
            drain_seen_d = 1'b0;
        end
        if (bus.flush_i) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q          <= '0;
            tag_q        <= '0;
            rm_q         <= '0;
            sp_q         <= '0;
            occ_q        <= '0;
            state_q      <= S_IDLE;
            drain_seen_q <= 1'b0;
        end else begin
            v_q          <= v_d;
            tag_q        <= tag_d;
            rm_q         <= rm_d;
            sp_q         <= sp_d;
            occ_q        <= occ_d;
            state_q      <= state_d;
            drain_seen_q <= drain_seen_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready_o    = in_ready;
    assign bus.out_valid_o   = out_valid;
    assign bus.out_tag_o     = tag_q[NUM_STAGES-1];
    assign bus.out_rm_o      = rm_q[NUM_STAGES-1];
    assign bus.out_special_o = sp_q[NUM_STAGES-1];
    assign bus.stage_en_o    = stage_en;
    assign bus.dp_en_o       = dp_en;
    assign bus.occupancy_o   = occ_q;
    assign bus.drain_done_o  = drain_done;

endmodule
